// File: rtl/uart_tx_param_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_param_if
// Purpose : request/status bundle between a word producer and uart_tx_param.
// Signals :
//   i_tx_start     producer -> tx   request to send i_data
//   i_data         producer -> tx   word to send (DATA_BITS wide)
//   i_parity_mode  producer -> tx   00 none, 01 even, 10 odd, 11 none
//   i_two_stop     producer -> tx   1 = two stop bits
//   o_ready        tx -> producer   a word can be accepted this cycle
//   o_tx_done      tx -> producer   transmitter fully idle
// Modports: master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_tx_start;
   logic [DATA_BITS-1:0] i_data;
   logic [1:0]           i_parity_mode;
   logic                 i_two_stop;
   logic                 o_ready;
   logic                 o_tx_done;

   modport master (
      output i_tx_start, i_data, i_parity_mode, i_two_stop,
      input  o_ready, o_tx_done
   );

   modport slave (
      input  i_tx_start, i_data, i_parity_mode, i_two_stop,
      output o_ready, o_tx_done
   );
endinterface

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_param
// Purpose : parametrised UART transmitter. Serialises one DATA_BITS word per
//           frame (start, data LSB first, optional parity, 1 or 2 stop bits),
//           paced by an external baud strobe carrying OVERSAMPLE ticks per bit.
// Parameters:
//   DATA_BITS   data bits per frame, 5..9
//   OVERSAMPLE  i_baud_tick pulses per serial bit, >= 2
//   FIFO_DEPTH  input queue entries, power of 2 >= 2 (queue build only)
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   i_baud_tick  1-clk strobe, OVERSAMPLE per bit time
//   bus          uart_tx_param_if.slave: start/data/parity/stop requests,
//                ready and done status
//   o_tx         serial line, idle high
// Build option:
//   UART_TX_FIFO_EN  when defined, requests are queued in a FIFO_DEPTH-entry
//                    FIFO and o_ready means "not full"; otherwise o_ready is
//                    high only while the transmitter is idle.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module uart_tx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_baud_tick,
   uart_tx_param_if.slave bus,
   output logic           o_tx
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   // Reject unsupported parameter sets at elaboration.
   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_param: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Parity is generated only for modes 01 (even) and 10 (odd).
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == 2'b01) || (mode == 2'b10);
   endfunction

   // Even parity = XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                       input logic [1:0]           mode);
      return (^data) ^ (mode == 2'b10);
   endfunction

   state_e               state_q, state_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 two_stop_q, two_stop_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;

   logic                 tick_end_s;
   logic                 load_s;
   logic [DATA_BITS-1:0] load_data_s;
   logic [1:0]           load_mode_s;
   logic                 load_two_stop_s;

`ifdef UART_TX_FIFO_EN
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = DATA_BITS + 3;

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_s;
   logic               pop_s;
   logic [ENTRY_W-1:0] head_s;

   // Queue bookkeeping: push/pop decisions, pointer wrap and occupancy.
   always_comb begin
      // ready_q is registered "not full", so it also gates the push.
      push_s = bus.i_tx_start && ready_q;
      pop_s  = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
      head_s = mem_q[rd_ptr_q];
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
   end

   assign load_s          = pop_s;
   assign load_data_s     = head_s[ENTRY_W-1:3];
   assign load_mode_s     = head_s[2:1];
   assign load_two_stop_s = head_s[0];

   // Queue storage and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {ENTRY_W{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.i_data, bus.i_parity_mode, bus.i_two_stop};
         end
      end
   end
`else
   // Without a queue the request is taken straight into the shift register.
   assign load_s          = bus.i_tx_start && ready_q;
   assign load_data_s     = bus.i_data;
   assign load_mode_s     = bus.i_parity_mode;
   assign load_two_stop_s = bus.i_two_stop;
`endif

   assign tick_end_s = i_baud_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

   // Frame sequencer: next state, bit timing and next line/status values.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;

      // Tick counter only runs while a frame is on the line.
      if ((state_q != ST_IDLE) && i_baud_tick) begin
         if (tick_end_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
         end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
         end
      end else begin
         tick_cnt_d = tick_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (load_s) begin
               // Frame settings are captured here so later input changes
               // cannot disturb the frame in flight.
               state_d    = ST_START;
               tx_d       = 1'b0;
               tick_cnt_d = {TICK_W{1'b0}};
               bit_cnt_d  = {BIT_W{1'b0}};
               stop_cnt_d = 1'b0;
               shift_d    = load_data_s;
               par_en_d   = parity_enabled(load_mode_s);
               par_bit_d  = parity_bit(load_data_s, load_mode_s);
               two_stop_d = load_two_stop_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_end_s) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               tx_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (tick_end_s) begin
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  // shift_q[0] is on the line; expose the next bit.
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               tx_d = tx_q;
            end
         end
         ST_PARITY: begin
            if (tick_end_s) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end else begin
               tx_d = tx_q;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (tick_end_s) begin
               if (two_stop_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               stop_cnt_d = stop_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Status flags are derived from the next state so they flip on the same
   // edge as the state itself.
   always_comb begin
`ifdef UART_TX_FIFO_EN
      ready_d = (count_d != CNT_W'(FIFO_DEPTH));
      done_d  = (state_d == ST_IDLE) && (count_d == {CNT_W{1'b0}});
`else
      ready_d = (state_d == ST_IDLE);
      done_d  = (state_d == ST_IDLE);
`endif
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= {TICK_W{1'b0}};
         bit_cnt_q  <= {BIT_W{1'b0}};
         shift_q    <= {DATA_BITS{1'b0}};
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign o_tx          = tx_q;
   assign bus.o_ready   = ready_q;
   assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_param
// Directed + random frames for uart_tx_param with DATA_BITS=8, OVERSAMPLE=16
// and a baud strobe every 4 clocks. Expected line levels come from a frame
// model built from the data word, parity mode and stop count.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;
   localparam int DB       = 8;
   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
`ifdef UART_TX_FIFO_EN
   localparam int PIPE = 1;   // push then pop: one extra clock before START
`else
   localparam int PIPE = 0;
`endif

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic baud_tick = 1'b0;
   logic tick_en   = 1'b1;
   logic o_tx;
   int   div       = 0;
   int   tests     = 0;
   int   fails     = 0;

   uart_tx_param_if #(.DATA_BITS(DB)) bus ();

   uart_tx_param #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_baud_tick(baud_tick),
      .bus        (bus),
      .o_tx       (o_tx)
   );

   always #5 clk = ~clk;

   // Baud strobe: one clock in every TICK_DIV, updated on the falling edge.
   always @(negedge clk) begin
      div       = (div + 1) % TICK_DIV;
      baud_tick = (div == 0) && tick_en;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame: start, data LSB first, parity from the count of ones,
   // then one or two stop bits. Returns the number of bit times.
   function automatic int frame_bits(input logic [DB-1:0] d, input logic [1:0] mode,
                                     input logic two, output logic [15:0] bits);
      int n    = 0;
      int ones = 0;
      bits = 16'h0000;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < DB; i++) begin
         bits[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (mode == 2'b01) begin bits[n] = (ones % 2 == 1); n++; end
      else if (mode == 2'b10) begin bits[n] = (ones % 2 == 0); n++; end
      bits[n] = 1'b1; n++;
      if (two) begin bits[n] = 1'b1; n++; end
      return n;
   endfunction

   // Hold a request until it is accepted, then scramble the request inputs.
   task automatic push(input string tag, input logic [DB-1:0] d, input logic [1:0] mode,
                       input logic two);
      int guard = 0;
      bus.i_tx_start    = 1'b1;
      bus.i_data        = d;
      bus.i_parity_mode = mode;
      bus.i_two_stop    = two;
      while (bus.o_ready !== 1'b1 && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      bus.i_tx_start    = 1'b0;
      bus.i_data        = DB'($urandom);
      bus.i_parity_mode = 2'($urandom);
      bus.i_two_stop    = 1'($urandom);
      check({tag, "_accept"}, 32'(guard < 4000), 32'd1);
   endtask

   // Watch one frame tick by tick against the model. abort_k >= 0 asserts
   // reset at that tick; poke_k >= 0 pulses a stray request at that tick.
   task automatic check_frame(input string tag, input logic [DB-1:0] d, input logic [1:0] mode,
                              input logic two, input int exp_wait, input logic exp_done,
                              input int abort_k, input int poke_k);
      logic [15:0] bits;
      int n;
      int k        = 0;
      int wait_n   = 0;
      int bad_busy = 0;
      int bad_bit[16];
      logic seen    = 1'b0;
      logic poked   = 1'b0;
      logic poke_on = 1'b0;
      n = frame_bits(d, mode, two, bits);
      foreach (bad_bit[i]) bad_bit[i] = 0;
      while (k < n * OS) begin
         @(negedge clk);
         #1;
         if (!seen) begin
            if (o_tx === 1'b0) seen = 1'b1;
            else begin
               wait_n++;
               if (wait_n > 200) break;
            end
         end
         if (seen) begin
            if (bus.o_tx_done !== 1'b0) bad_busy++;
            if (poke_on) begin
               bus.i_tx_start = 1'b0;
               poke_on = 1'b0;
            end else if (k == poke_k && !poked) begin
               bus.i_tx_start = 1'b1;
               bus.i_data     = ~d;
               poked   = 1'b1;
               poke_on = 1'b1;
            end
            if (abort_k >= 0 && k == abort_k) begin
               #1 rst = 1'b1;
               #1;
               check({tag, "_rst_tx"},    32'(o_tx),          32'd1);
               check({tag, "_rst_done"},  32'(bus.o_tx_done), 32'd1);
               check({tag, "_rst_ready"}, 32'(bus.o_ready),   32'd1);
               @(negedge clk);
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            if (baud_tick) begin
               if (o_tx !== bits[k / OS]) bad_bit[k / OS]++;
               k++;
            end
         end
      end
      check({tag, "_start_wait"}, 32'(wait_n), 32'(exp_wait));
      if (!seen) return;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_bit%0d_bad_ticks", tag, i), 32'(bad_bit[i]), 32'd0);
      end
      check({tag, "_busy_done"}, 32'(bad_busy), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_end_tx"},   32'(o_tx),          32'd1);
      check({tag, "_end_done"}, 32'(bus.o_tx_done), 32'(exp_done));
      if (exp_done) check({tag, "_end_ready"}, 32'(bus.o_ready), 32'd1);
   endtask

   // Line must stay idle and done for a while (no spurious frame).
   task automatic check_quiet(input string tag, input int clks);
      int bad = 0;
      for (int i = 0; i < clks; i++) begin
         @(negedge clk);
         #1;
         if (o_tx !== 1'b1 || bus.o_tx_done !== 1'b1) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [DB-1:0] rd;
      logic [1:0]    rm;
      logic          rt;
      int bad_tx, bad_done, bad_ready;
      logic [DB-1:0] fd [5];

      bus.i_tx_start    = 1'b0;
      bus.i_data        = '0;
      bus.i_parity_mode = 2'b00;
      bus.i_two_stop    = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset_tx",    32'(o_tx),          32'd1);
      check("reset_done",  32'(bus.o_tx_done), 32'd1);
      check("reset_ready", 32'(bus.o_ready),   32'd1);
      rst = 1'b0;

      // Idle after release, no request
      bad_tx = 0; bad_done = 0; bad_ready = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (o_tx !== 1'b1) bad_tx++;
         if (bus.o_tx_done !== 1'b1) bad_done++;
         if (bus.o_ready !== 1'b1) bad_ready++;
      end
      check("idle_tx",    32'(bad_tx),    32'd0);
      check("idle_done",  32'(bad_done),  32'd0);
      check("idle_ready", 32'(bad_ready), 32'd0);

      // 0xA5, no parity, one stop
      push("a5", 8'hA5, 2'b00, 1'b0);
      check_frame("a5", 8'hA5, 2'b00, 1'b0, PIPE, 1'b1, -1, -1);

      // 0x07 even / odd / two stop bits
      push("p_even", 8'h07, 2'b01, 1'b0);
      check_frame("p_even", 8'h07, 2'b01, 1'b0, PIPE, 1'b1, -1, -1);
      push("p_odd", 8'h07, 2'b10, 1'b0);
      check_frame("p_odd", 8'h07, 2'b10, 1'b0, PIPE, 1'b1, -1, -1);
      push("p_two", 8'h07, 2'b01, 1'b1);
      check_frame("p_two", 8'h07, 2'b01, 1'b1, PIPE, 1'b1, -1, -1);
      push("p_rsv", 8'h07, 2'b11, 1'b0);
      check_frame("p_rsv", 8'h07, 2'b11, 1'b0, PIPE, 1'b1, -1, -1);

`ifndef UART_TX_FIFO_EN
      // Stray request mid-frame is ignored
      push("poke", 8'h96, 2'b10, 1'b0);
      check_frame("poke", 8'h96, 2'b10, 1'b0, PIPE, 1'b1, -1, 3 * OS + 2);
      check_quiet("poke_quiet", 300);
`endif

      // Reset during data bit 3 (frame bit 4), then a clean 0x3C frame
      push("abort", 8'h5A, 2'b01, 1'b1);
      check_frame("abort", 8'h5A, 2'b01, 1'b1, PIPE, 1'b1, 4 * OS + 5, -1);
      check_quiet("abort_quiet", 100);
      push("after_rst", 8'h3C, 2'b00, 1'b0);
      check_frame("after_rst", 8'h3C, 2'b00, 1'b0, PIPE, 1'b1, -1, -1);

      // Random back-to-back frames
      for (int i = 0; i < 8; i++) begin
         rd = DB'($urandom);
         rm = 2'($urandom_range(0, 3));
         rt = 1'($urandom_range(0, 1));
         push($sformatf("rnd%0d", i), rd, rm, rt);
         check_frame($sformatf("rnd%0d", i), rd, rm, rt, PIPE, 1'b1, -1, -1);
      end

`ifdef UART_TX_FIFO_EN
      // Five words back-to-back, a sixth dropped while full
      tick_en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         fd[i] = DB'($urandom);
         push($sformatf("fifo_push%0d", i), fd[i], 2'b01, 1'b0);
      end
      check("fifo_full_ready", 32'(bus.o_ready), 32'd0);
      bus.i_tx_start = 1'b1;
      bus.i_data     = 8'hFF;
      @(posedge clk);
      #1;
      bus.i_tx_start = 1'b0;
      tick_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_frame($sformatf("fifo%0d", i), fd[i], 2'b01, 1'b0, 0, (i == 4), -1, -1);
      end
      check_quiet("fifo_quiet", 300);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
